// File: rtl/adder_stim_gen.sv
// Stimulus generator and checker for a registered adder: drives LFSR or sweep
// operands with a one-cycle valid strobe and scores each returned sum.
module adder_stim_gen #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned NUM_TXN = 16,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              valid,
    input  logic [DATA_W:0]   c,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pass_cnt,
    output logic [15:0]       err_cnt,
    output logic              err_flag,
    output logic [15:0]       first_err_idx
);
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_DONE} state_t;

    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int unsigned CNT_W     = $clog2(LATENCY + 1);

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    state_t              r_state;
    state_t              w_next;
    logic                r_mode;
    logic [15:0]         r_lfsr;
    logic [15:0]         r_idx;
    logic [CNT_W-1:0]    r_wcnt;
    logic [DATA_W:0]     r_exp;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [15:0]         r_pass;
    logic [15:0]         r_err;
    logic                r_flag;
    logic [15:0]         r_first;

    logic                w_last_wait;
    logic [16:0]         w_idx_inc;
    logic                w_run_end;
    logic                w_load;
    logic                w_load_mode;
    logic [2*DATA_W-1:0] w_sweep;
    logic [DATA_W-1:0]   w_op_a;
    logic [DATA_W-1:0]   w_op_b;

    assign w_last_wait = (r_state == S_WAIT) && (r_wcnt == CNT_W'(LATENCY));
    assign w_idx_inc   = {1'b0, r_idx} + 17'd1;
    assign w_run_end   = (w_idx_inc == 17'(NUM_TXN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        valid  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_DRIVE;
            S_DRIVE: begin
                valid  = 1'b1;
                busy   = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (w_last_wait) w_next = w_run_end ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operands are captured on the edge entering DRIVE, so they are already
    // stable when valid rises; the first transaction takes mode straight from the port.
    always_comb begin
        w_load      = (w_next == S_DRIVE);
        w_load_mode = (r_state == S_IDLE) ? mode : r_mode;
        w_sweep     = (r_state == S_IDLE) ? '0 : w_idx_inc[2*DATA_W-1:0];
        w_op_a      = w_load_mode ? w_sweep[DATA_W-1:0]        : r_lfsr[DATA_W-1:0];
        w_op_b      = w_load_mode ? w_sweep[2*DATA_W-1:DATA_W] : r_lfsr[2*DATA_W-1:DATA_W];
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode  <= 1'b0;
            r_lfsr  <= SEED_EFF;
            r_idx   <= '0;
            r_wcnt  <= '0;
            r_exp   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_pass  <= '0;
            r_err   <= '0;
            r_flag  <= 1'b0;
            r_first <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_mode  <= mode;
                r_idx   <= '0;
                r_pass  <= '0;
                r_err   <= '0;
                r_flag  <= 1'b0;
                r_first <= '0;
            end
            if (w_load) begin
                r_a    <= w_op_a;
                r_b    <= w_op_b;
                r_exp  <= {1'b0, w_op_a} + {1'b0, w_op_b};
                r_lfsr <= lfsr_step(r_lfsr);
            end
            if (r_state == S_DRIVE)     r_wcnt <= CNT_W'(1);
            else if (r_state == S_WAIT) r_wcnt <= r_wcnt + 1'b1;
            if (w_last_wait) begin
                if (c == r_exp) begin
                    r_pass <= r_pass + 16'd1;
                end else begin
                    if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
                    if (!r_flag) begin
                        r_flag  <= 1'b1;
                        r_first <= r_idx;
                    end
                end
                r_idx <= w_idx_inc[15:0];
            end
        end
    end

    assign a             = r_a;
    assign b             = r_b;
    assign pass_cnt      = r_pass;
    assign err_cnt       = r_err;
    assign err_flag      = r_flag;
    assign first_err_idx = r_first;
endmodule

// File: tb/tb_adder_stim_gen.sv
// Bench for adder_stim_gen: plays a faultable registered adder and checks every
// output each cycle against a per-run schedule computed from the run's rules.
module tb_adder_stim_gen;
    localparam int DW      = 4;
    localparam int LAT     = 2;
    localparam int N       = 256;
    localparam int P       = LAT + 1;
    localparam int END_REL = N * P;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mode;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          valid;
    logic [DW:0]   c;
    logic          busy;
    logic          done;
    logic [15:0]   pass_cnt;
    logic [15:0]   err_cnt;
    logic          err_flag;
    logic [15:0]   first_err_idx;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    int fault_mode = 0;
    int fault_a    = 0;
    int got_a, got_b, got_lat, got_pass, got_err, got_first, got_flag;

    adder_stim_gen #(.DATA_W(DW), .LATENCY(LAT), .NUM_TXN(N), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .a(a), .b(b), .valid(valid), .c(c), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt), .err_flag(err_flag),
        .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) t <= t + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, t, act, exp);
        end
    endtask

    function automatic bit faulty(input int av);
        return fault_mode == 1 || (fault_mode == 2 && av == fault_a);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [DW:0] adder_out(input int av, input int bv);
        int s;
        s = av + bv + (faulty(av) ? 1 : 0);
        return s[DW:0];
    endfunction

    // Adder under the generator: LAT-stage pipeline, bubbles read as zero.
    logic [DW:0] pipe [LAT];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= valid ? adder_out(int'(a), int'(b)) : '0;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign c = pipe[LAT-1];

    // Reference: each accepted start fixes the whole run's schedule up front.
    bit          run_valid = 0;
    int          s_cyc;
    int          ops_a [N];
    int          ops_b [N];
    int          cum_pass [N+1];
    int          cum_err  [N+1];
    int          first_k;
    int          pre_a, pre_b, pre_pass, pre_err, pre_first, pre_flag;
    logic [15:0] lfsr_m = SEED;

    always @(negedge clk) begin
        int ea, eb, ep, ee, ef, efl, ev, ebusy, edone, rel, cmpl, k, src;
        bit idle;
        if (reset) begin
            check("rst_valid", valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_a", int'(a), 0);
            check("rst_b", int'(b), 0);
            check("rst_pass", int'(pass_cnt), 0);
            check("rst_err", int'(err_cnt), 0);
            check("rst_flag", err_flag, 0);
            check("rst_first", int'(first_err_idx), 0);
            run_valid = 0;
            lfsr_m    = SEED;
        end else begin
            ea = 0; eb = 0; ep = 0; ee = 0; ef = 0; efl = 0;
            ev = 0; ebusy = 0; edone = 0; idle = 1;
            if (run_valid) begin
                rel = t - s_cyc;
                if (rel == 0) begin
                    ea = pre_a; eb = pre_b; ep = pre_pass; ee = pre_err;
                    ef = pre_first; efl = pre_flag; idle = 0;
                end else begin
                    cmpl  = (rel <= END_REL) ? (rel - 1) / P : N;
                    k     = (rel <= END_REL) ? (rel - 1) / P : N - 1;
                    ea    = ops_a[k];
                    eb    = ops_b[k];
                    ep    = cum_pass[cmpl];
                    ee    = cum_err[cmpl];
                    efl   = (first_k >= 0 && first_k < cmpl) ? 1 : 0;
                    ef    = efl ? first_k : 0;
                    ebusy = (rel <= END_REL) ? 1 : 0;
                    ev    = (ebusy && (rel - 1) % P == 0) ? 1 : 0;
                    edone = (rel == END_REL + 1) ? 1 : 0;
                    idle  = rel > END_REL + 1;
                end
            end
            check("valid", valid, ev);
            check("busy", busy, ebusy);
            check("done", done, edone);
            check("a", int'(a), ea);
            check("b", int'(b), eb);
            check("pass_cnt", int'(pass_cnt), ep);
            check("err_cnt", int'(err_cnt), ee);
            check("err_flag", err_flag, efl);
            check("first_err_idx", int'(first_err_idx), ef);
            if (start && idle) begin
                pre_a = ea; pre_b = eb; pre_pass = ep; pre_err = ee;
                pre_first = ef; pre_flag = efl;
                s_cyc = t;
                run_valid = 1;
                cum_pass[0] = 0;
                cum_err[0]  = 0;
                first_k     = -1;
                for (int i = 0; i < N; i++) begin
                    src = mode ? i : int'(lfsr_m);
                    lfsr_m = lfsr_next(lfsr_m);
                    ops_a[i] = src % (2 ** DW);
                    ops_b[i] = (src / (2 ** DW)) % (2 ** DW);
                    if (faulty(ops_a[i])) begin
                        cum_pass[i+1] = cum_pass[i];
                        cum_err[i+1]  = cum_err[i] + 1;
                        if (first_k < 0) first_k = i;
                    end else begin
                        cum_pass[i+1] = cum_pass[i] + 1;
                        cum_err[i+1]  = cum_err[i];
                    end
                end
            end
        end
    end

    task automatic run(input bit m, input int fm, input int fa, input bit poke);
        int  t0;
        bit  seen;
        fault_mode = fm;
        fault_a    = fa;
        @(posedge clk); #1 start = 1'b1; mode = m;
        @(posedge clk); #1 start = 1'b0; mode = 1'($urandom_range(0, 1));
        seen = 0;
        t0   = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (valid) begin
                seen = 1; t0 = t; got_a = int'(a); got_b = int'(b);
            end
        end
        if (!seen) check("first_valid_timeout", 0, 1);
        seen = 0;
        for (int i = 0; i < END_REL + 8 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen      = 1;
                got_lat   = t - t0;
                got_pass  = int'(pass_cnt);
                got_err   = int'(err_cnt);
                got_first = int'(first_err_idx);
                got_flag  = int'(err_flag);
                if (poke) begin
                    #1 start = 1'b1;
                    @(posedge clk); #1 start = 1'b0;
                end
            end else if (poke && i == 5) begin
                #1 start = 1'b1;
            end else if (poke && i == 6) begin
                #1 start = 1'b0;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int nvalid;
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_pass_cnt", int'(pass_cnt), 0);

        run(1'b0, 0, 0, 1'b0);
        check("lfsr_first_a", got_a, 1);
        check("lfsr_first_b", got_b, 14);
        check("lfsr_pass", got_pass, 256);
        check("lfsr_err", got_err, 0);

        run(1'b0, 0, 0, 1'b1);
        check("lfsr2_pass", got_pass, 256);

        run(1'b1, 0, 0, 1'b1);
        check("sweep_first_a", got_a, 0);
        check("sweep_first_b", got_b, 0);
        check("sweep_latency", got_lat, 768);
        check("sweep_pass", got_pass, 256);
        check("sweep_flag", got_flag, 0);

        run(1'b1, 1, 0, 1'b0);
        check("allbad_err", got_err, 256);
        check("allbad_pass", got_pass, 0);
        check("allbad_flag", got_flag, 1);
        check("allbad_first", got_first, 0);

        run(1'b1, 2, 2, 1'b0);
        check("a2bad_pass", got_pass, 240);
        check("a2bad_err", got_err, 16);
        check("a2bad_first", got_first, 2);

        for (int r = 0; r < 2; r++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            run(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        fault_mode = 0;
        @(posedge clk); #1 start = 1'b1; mode = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 20 && nvalid < 3; i++) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        check("abort_reached_txn2", nvalid, 3);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("abort_pass_zero", int'(pass_cnt), 0);
        check("abort_busy_zero", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        run(1'b1, 0, 0, 1'b0);
        check("rerun_pass", got_pass, 256);
        check("rerun_err", got_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
